serv_decode_pipe: RTL and testbench

SERV_DECODE_PIPE -- requirements
Module: serv_decode_pipe

---
 rtl/serv_params.sv | 102 ++++++++++
 rtl/serv_imm_rot.sv | 30 +++
 rtl/serv_decode_pipe.sv | 138 +++++++++++++
 tb/tb_serv_decode_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_params.sv
// Shared decode constants, types and the instruction decode function for the
// SERV decode pipeline. Opcode majors are instruction bits 6:2.
package serv_params;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // Bit positions inside the one-hot op_class vector.
    localparam int CLS_ALU       = 0;
    localparam int CLS_SHIFT_SLT = 1;
    localparam int CLS_MEM       = 2;
    localparam int CLS_BRANCH    = 3;
    localparam int CLS_UTYPE     = 4;
    localparam int CLS_JUMP      = 5;
    localparam int CLS_CSR       = 6;
    localparam int CLS_SYSTEM    = 7;

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    typedef struct packed {
        logic        illegal;
        logic [7:0]  op_class;
        logic [2:0]  funct3;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [31:0] imm;
    } decode_t;

    // Full decode of one raw word; used by both the bus and skid load paths.
    function automatic decode_t decode(input logic [31:0] w);
        decode_t    d;
        logic       s;
        logic       shift_slt;
        d.rd       = w[11:7];
        d.rs1      = w[19:15];
        d.rs2      = w[24:20];
        d.funct3   = w[14:12];
        d.illegal  = 1'b0;
        d.op_class = '0;
        d.imm      = '0;
        s          = w[31];
        // funct3 001/101 are shifts, 010/011 are set-less-than.
        shift_slt  = (w[14:12] == 3'b001) || (w[14:12] == 3'b101) ||
                     (w[14:12] == 3'b010) || (w[14:12] == 3'b011);
        if (w[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end else begin
            case (w[6:2])
                OPC_LOAD: begin
                    d.op_class[CLS_MEM] = 1'b1;
                    d.imm = {{20{s}}, w[31:20]};
                end
                OPC_STORE: begin
                    d.op_class[CLS_MEM] = 1'b1;
                    d.imm = {{20{s}}, w[31:25], w[11:7]};
                end
                OPC_OP_IMM: begin
                    d.op_class[shift_slt ? CLS_SHIFT_SLT : CLS_ALU] = 1'b1;
                    d.imm = {{20{s}}, w[31:20]};
                end
                OPC_OP: begin
                    d.op_class[shift_slt ? CLS_SHIFT_SLT : CLS_ALU] = 1'b1;
                end
                OPC_AUIPC, OPC_LUI: begin
                    d.op_class[CLS_UTYPE] = 1'b1;
                    d.imm = {w[31:12], 12'b0};
                end
                OPC_BRANCH: begin
                    d.op_class[CLS_BRANCH] = 1'b1;
                    d.imm = {{19{s}}, s, w[7], w[30:25], w[11:8], 1'b0};
                end
                OPC_JALR: begin
                    d.op_class[CLS_JUMP] = 1'b1;
                    d.imm = {{20{s}}, w[31:20]};
                end
                OPC_JAL: begin
                    d.op_class[CLS_JUMP] = 1'b1;
                    d.imm = {{11{s}}, s, w[19:12], w[20], w[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    // funct3 == 0 is ecall/ebreak/mret-style, others are CSR ops.
                    d.op_class[(w[14:12] == 3'b000) ? CLS_SYSTEM : CLS_CSR] = 1'b1;
                end
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/serv_imm_rot.sv
// 32-bit immediate register that rotates right by W bits per enable, so the
// low W bits present the immediate LSB-first to the bit-serial datapath.
module serv_imm_rot #(
    parameter int W = 1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [31:0]   i_imm,
    input  logic          i_en,
    output logic [W-1:0]  o_imm
);

    logic [31:0] imm_q;

    // Load wins over rotation; 32/W rotations return to the loaded value.
    always_ff @(posedge clk or negedge i_rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!i_rst_n) begin
            imm_q <= '0;
        end else if (i_load) begin
            imm_q <= i_imm;
        end else if (i_en) begin
            imm_q <= {imm_q[W-1:0], imm_q[31:W]};
        end
    end

    assign o_imm = imm_q[W-1:0];

endmodule

// File: rtl/serv_decode_pipe.sv
// Instruction decode stage: accepts fetched words, holds one live decoded
// instruction plus an optional one-entry skid, and streams its immediate.
module serv_decode_pipe
    import serv_params::*;
#(
    parameter int W    = 1,
    parameter int SKID = 1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_ibus_rdt,
    input  logic          i_ibus_valid,
    output logic          o_ibus_ready,
    input  logic          i_cnt_en,
    input  logic          i_cnt_done,
    output logic          o_insn_valid,
    output logic [W-1:0]  o_imm,
    output logic [4:0]    o_rf_rd_addr,
    output logic [4:0]    o_rf_rs1_addr,
    output logic [4:0]    o_rf_rs2_addr,
    output logic [2:0]    o_funct3,
    output logic [7:0]    o_op_class,
    output logic          o_illegal,
    output logic          o_skid_full
);

    localparam logic SKID_EN = (SKID != 0);

    state_t      state_q, state_d;
    logic        skid_full_q;
    logic [31:0] skid_word_q;
    logic        hs;
    logic        load;
    logic [31:0] load_word;
    logic        skid_store;
    logic        skid_take;
    decode_t     dec;

    assign o_ibus_ready = (state_q == EMPTY) | (SKID_EN & ~skid_full_q);
    assign hs           = i_ibus_valid & o_ibus_ready;
    assign o_insn_valid = (state_q == BUSY);
    assign o_skid_full  = SKID_EN & skid_full_q;

    // Next-state and load selection: skid entry is retired before new bus words.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d    = state_q;
        load       = 1'b0;
        load_word  = i_ibus_rdt;
        skid_store = 1'b0;
        skid_take  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (hs) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (i_cnt_done) begin
                    if (skid_full_q) begin
                        load      = 1'b1;
                        load_word = skid_word_q;
                        skid_take = 1'b1;
                    end else if (hs) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (hs) begin
                    skid_store = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign dec = decode(load_word);

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Skid occupancy flag; reset discards any parked word.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_full_q <= 1'b0;
        end else if (skid_store) begin
            skid_full_q <= 1'b1;
        end else if (skid_take) begin
            skid_full_q <= 1'b0;
        end
    end

    // Skid payload captured on a BUSY handshake.
    always_ff @(posedge clk) begin
        // NOTE: payload needs no reset; skid_full_q alone qualifies it.
        if (skid_store) begin
            skid_word_q <= i_ibus_rdt;
        end
    end

    // Decoded instruction fields, updated on every load.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rf_rd_addr  <= '0;
            o_rf_rs1_addr <= '0;
            o_rf_rs2_addr <= '0;
            o_funct3      <= '0;
            o_op_class    <= '0;
            o_illegal     <= 1'b0;
        end else if (load) begin
            o_rf_rd_addr  <= dec.rd;
            o_rf_rs1_addr <= dec.rs1;
            o_rf_rs2_addr <= dec.rs2;
            o_funct3      <= dec.funct3;
            o_op_class    <= dec.op_class;
            o_illegal     <= dec.illegal;
        end
    end

    serv_imm_rot #(
        .W (W)
    ) u_imm_rot (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_load  (load),
        .i_imm   (dec.imm),
        .i_en    (i_cnt_en),
        .o_imm   (o_imm)
    );

endmodule

// File: tb/tb_serv_decode_pipe.sv
// Bench for serv_decode_pipe: two instances (W=4/SKID=1 and W=1/SKID=0) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_serv_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rdt;
    logic        valid, cnt_en, cnt_done;

    logic        ready_o[2], ivalid_o[2], ill_o[2], sf_o[2];
    logic [4:0]  rd_o[2], rs1_o[2], rs2_o[2];
    logic [2:0]  f3_o[2];
    logic [7:0]  cls_o[2];
    logic [31:0] imm_o[2];
    logic [3:0]  imm4;
    logic [0:0]  imm1;

    assign imm_o[0] = {28'b0, imm4};
    assign imm_o[1] = {31'b0, imm1};

    always #5 clk = ~clk;

    serv_decode_pipe #(.W(4), .SKID(1)) u_dut4 (
        .clk(clk), .i_rst_n(rst_n), .i_ibus_rdt(rdt), .i_ibus_valid(valid),
        .o_ibus_ready(ready_o[0]), .i_cnt_en(cnt_en), .i_cnt_done(cnt_done),
        .o_insn_valid(ivalid_o[0]), .o_imm(imm4), .o_rf_rd_addr(rd_o[0]),
        .o_rf_rs1_addr(rs1_o[0]), .o_rf_rs2_addr(rs2_o[0]), .o_funct3(f3_o[0]),
        .o_op_class(cls_o[0]), .o_illegal(ill_o[0]), .o_skid_full(sf_o[0]));

    serv_decode_pipe #(.W(1), .SKID(0)) u_dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_ibus_rdt(rdt), .i_ibus_valid(valid),
        .o_ibus_ready(ready_o[1]), .i_cnt_en(cnt_en), .i_cnt_done(cnt_done),
        .o_insn_valid(ivalid_o[1]), .o_imm(imm1), .o_rf_rd_addr(rd_o[1]),
        .o_rf_rs1_addr(rs1_o[1]), .o_rf_rs2_addr(rs2_o[1]), .o_funct3(f3_o[1]),
        .o_op_class(cls_o[1]), .o_illegal(ill_o[1]), .o_skid_full(sf_o[1]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    int          wid[2]     = '{4, 1};
    bit          skid_en[2] = '{1'b1, 1'b0};
    bit          busy[2], has[2], pend_v[2];
    logic [31:0] cur[2], pend_w[2];
    int          steps[2];

    // ISA-level decode written from the RV32I opcode table.
    function automatic void ref_decode(input logic [31:0] w, output logic [7:0] cls,
                                       output logic ill, output logic [31:0] imm);
        logic [2:0] f3;
        logic [31:0] sx;
        f3  = w[14:12];
        sx  = 32'($signed(w) >>> 31);
        cls = 8'h00; ill = 1'b0; imm = 32'h0;
        case (w[6:0])
            7'h03: begin cls = 8'h04; imm = 32'($signed(w) >>> 20); end
            7'h23: begin cls = 8'h04; imm = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]); end
            7'h13: begin cls = (f3 inside {3'd1, 3'd2, 3'd3, 3'd5}) ? 8'h02 : 8'h01;
                         imm = 32'($signed(w) >>> 20); end
            7'h33: cls = (f3 inside {3'd1, 3'd2, 3'd3, 3'd5}) ? 8'h02 : 8'h01;
            7'h17, 7'h37: begin cls = 8'h10; imm = w & 32'hFFFF_F000; end
            7'h63: begin cls = 8'h08;
                         imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1); end
            7'h67: begin cls = 8'h20; imm = 32'($signed(w) >>> 20); end
            7'h6F: begin cls = 8'h20;
                         imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1); end
            7'h73: cls = (f3 == 3'd0) ? 8'h80 : 8'h40;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            busy[d] = 0; has[d] = 0; pend_v[d] = 0; steps[d] = 0;
            cur[d] = '0; pend_w[d] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            logic [7:0]  c;
            logic        il;
            logic [31:0] im, r, w;
            int          s;
            w = has[d] ? cur[d] : 32'h0;
            if (has[d]) ref_decode(w, c, il, im);
            else begin c = 8'h0; il = 1'b0; im = 32'h0; end
            s = (steps[d] * wid[d]) % 32;
            r = ((im >> s) | (im << (32 - s))) & ((32'd1 << wid[d]) - 1);
            check($sformatf("d%0d.ready", d), 32'(ready_o[d]), 32'(!busy[d] || (skid_en[d] && !pend_v[d])));
            check($sformatf("d%0d.insn_valid", d), 32'(ivalid_o[d]), 32'(busy[d]));
            check($sformatf("d%0d.skid_full", d), 32'(sf_o[d]), 32'(pend_v[d]));
            check($sformatf("d%0d.rd", d), 32'(rd_o[d]), 32'(w[11:7]));
            check($sformatf("d%0d.rs1", d), 32'(rs1_o[d]), 32'(w[19:15]));
            check($sformatf("d%0d.rs2", d), 32'(rs2_o[d]), 32'(w[24:20]));
            check($sformatf("d%0d.funct3", d), 32'(f3_o[d]), 32'(w[14:12]));
            check($sformatf("d%0d.op_class", d), 32'(cls_o[d]), 32'(c));
            check($sformatf("d%0d.illegal", d), 32'(ill_o[d]), 32'(il));
            check($sformatf("d%0d.imm", d), imm_o[d], r);
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            bit rdy, hs, ld;
            rdy = !busy[d] || (skid_en[d] && !pend_v[d]);
            hs  = valid && rdy;
            ld  = 0;
            if (!busy[d]) begin
                if (hs) begin cur[d] = rdt; ld = 1; busy[d] = 1; end
            end else if (cnt_done) begin
                if (pend_v[d]) begin cur[d] = pend_w[d]; pend_v[d] = 0; ld = 1; end
                else if (hs) begin cur[d] = rdt; ld = 1; end
                else busy[d] = 0;
            end else if (hs) begin
                pend_v[d] = 1; pend_w[d] = rdt;
            end
            if (ld) begin has[d] = 1; steps[d] = 0; end
            else if (cnt_en) steps[d] = (steps[d] + 1) % 32;
        end
    endtask

    // One cycle: check at the falling edge, drive, advance model, clock.
    task automatic step(input logic v, input logic [31:0] w, input logic ce, input logic cd);
        check_outputs();
        valid = v; rdt = w; cnt_en = ce; cnt_done = cd;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_word();
        logic [6:0]  ops[10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(7) == 0) return r;
        return {r[31:7], ops[$urandom_range(9)]};
    endfunction

    int seq34[8] = '{0, 0, 0, 5, 4, 3, 2, 1};

    initial begin
        logic [31:0] acc;
        rst_n = 1'b0; valid = 0; rdt = '0; cnt_en = 0; cnt_done = 0;
        model_reset();
        @(negedge clk);
        check("rst.ready", 32'(ready_o[0]), 32'd1);
        check("rst.insn_valid", 32'(ivalid_o[0]), 32'd0);
        check("rst.op_class", 32'(cls_o[0]), 32'd0);
        check("rst.illegal", 32'(ill_o[0]), 32'd0);
        check("rst.imm", imm_o[0], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // addi x1,x2,-1 : immediate all ones, every nibble is F.
        step(1, 32'hFFF1_0093, 0, 0);
        check("addi.class", 32'(cls_o[0]), 32'h01);
        check("addi.rd", 32'(rd_o[0]), 32'd1);
        check("addi.rs1", 32'(rs1_o[0]), 32'd2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("addi.imm%0d", i), imm_o[0], 32'hF);
            step(0, 0, 1, 0);
        end
        step(0, 0, 0, 1);

        // lui x5,0x12345 : nibbles 0,0,0,5,4,3,2,1.
        step(1, 32'h1234_52B7, 0, 0);
        check("lui.class", 32'(cls_o[0]), 32'h10);
        check("lui.rd", 32'(rd_o[0]), 32'd5);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lui.imm%0d", i), imm_o[0], 32'(seq34[i]));
            step(0, 0, 1, 0);
        end
        step(0, 0, 0, 1);

        // jal x1,12 on the W=1 instance : 32 serial bits rebuild 12.
        step(1, 32'h00C0_00EF, 0, 0);
        check("jal.class", 32'(cls_o[1]), 32'h20);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            acc[i] = imm_o[1][0];
            step(0, 0, 1, 0);
        end
        check("jal.serial_imm", acc, 32'h0000_000C);
        step(0, 0, 0, 1);

        // All-zero word is illegal but still occupies the stage.
        step(1, 32'h0, 0, 0);
        check("zero.illegal", 32'(ill_o[0]), 32'd1);
        check("zero.class", 32'(cls_o[0]), 32'd0);
        check("zero.insn_valid", 32'(ivalid_o[0]), 32'd1);
        step(0, 0, 0, 1);

        // Back-to-back words, retirement held off for 10 cycles.
        step(1, 32'h0010_0193, 0, 0);
        step(1, 32'h0050_0313, 0, 0);
        for (int i = 0; i < 10; i++) begin
            check("skid.full", 32'(sf_o[0]), 32'd1);
            check("skid.ready", 32'(ready_o[0]), 32'd0);
            check("skid.rd_hold", 32'(rd_o[0]), 32'd3);
            step(0, 0, 0, 0);
        end
        step(0, 0, 0, 1);
        check("skid.second_rd", 32'(rd_o[0]), 32'd6);
        check("skid.second_valid", 32'(ivalid_o[0]), 32'd1);
        check("skid.drained", 32'(sf_o[0]), 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(1) == 1, rand_word(), $urandom_range(9) < 7,
                 $urandom_range(6) == 0);
        end

        // Reset while busy with the skid occupied.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 32'h0010_0193, 0, 0);
        step(1, 32'hFFF1_0093, 1, 0);
        check("pre_rst.skid_full", 32'(sf_o[0]), 32'd1);
        valid = 0; cnt_en = 0; cnt_done = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst.insn_valid", 32'(ivalid_o[0]), 32'd0);
        check("mid_rst.skid_full", 32'(sf_o[0]), 32'd0);
        check("mid_rst.imm", imm_o[0], 32'd0);
        check("mid_rst.rd", 32'(rd_o[0]), 32'd0);
        check("mid_rst.rs1", 32'(rs1_o[0]), 32'd0);
        check("mid_rst.class", 32'(cls_o[0]), 32'd0);
        check("mid_rst.illegal", 32'(ill_o[0]), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst.ready", 32'(ready_o[0]), 32'd1);
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(1) == 1, rand_word(), $urandom_range(9) < 7,
                 $urandom_range(6) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
